// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready pipeline register with retain/clear; optional skid entry via PIPE_STAGE_SKID_EN
module pipe_stage_elastic #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             retain,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  logic             r_m_v;
  logic [WIDTH-1:0] r_m_d;
  logic             w_s_v;
  logic [WIDTH-1:0] w_s_d;
  logic             w_acc;
  logic             w_emit;
  logic             w_m_load;

  assign out_valid = r_m_v & ~retain;
  assign out_data  = r_m_d;
  assign occupancy = {1'b0, r_m_v} + {1'b0, w_s_v};
  assign w_acc     = in_valid & in_ready;
  assign w_emit    = out_valid & out_ready;
  assign w_m_load  = (w_emit | ~r_m_v) & (w_s_v | w_acc);

`ifdef PIPE_STAGE_SKID_EN
  logic             r_s_v;
  logic [WIDTH-1:0] r_s_d;
  logic             w_s_load;

  assign w_s_v    = r_s_v;
  assign w_s_d    = r_s_d;
  assign w_s_load = w_acc & r_m_v & (r_s_v | ~w_emit);
  assign in_ready = ~r_s_v & ~retain;

  // skid entry: catches an accept that main cannot take, drains into main on emit
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_s_v <= 1'b0;
      r_s_d <= RESET_DATA;
    end else if (clear) begin
      r_s_v <= 1'b0;
    end else if (!retain) begin
      r_s_v <= w_s_load | (r_s_v & ~w_emit);
      if (w_s_load) r_s_d <= in_data;
    end
  end
`else
  assign w_s_v    = 1'b0;
  assign w_s_d    = '0;
  assign in_ready = (~r_m_v | out_ready) & ~retain;
`endif

  // main entry: refilled from skid first to keep FIFO order, otherwise from input
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_m_v <= 1'b0;
      r_m_d <= RESET_DATA;
    end else if (clear) begin
      r_m_v <= 1'b0;
    end else if (!retain) begin
      r_m_v <= w_s_v | w_acc | (r_m_v & ~w_emit);
      if (w_m_load) r_m_d <= w_s_v ? w_s_d : in_data;
    end
  end
endmodule
